// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - successive-approximation ADC controller driving a binary-weighted DAC
// Samples, runs N bit trials MSB-first against the comparator, then offers the code on valid/ready.
module sar_adc_ctrl #(
   parameter int N             = 8,
   parameter int SAMPLE_CYCLES = 2,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         cmp,
   output logic         sample,
   output logic [N-1:0] dac_code,
   output logic         busy,
   output logic [N-1:0] result,
   output logic         valid,
   input  logic         ready
);

   localparam int TRIAL = SETTLE_CYCLES + 1;
   localparam int MAXC  = (SAMPLE_CYCLES > TRIAL) ? SAMPLE_CYCLES : TRIAL;
   localparam int CW    = $clog2(MAXC + 1);
   localparam int KW    = $clog2(N);

   typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONVERT, S_DONE} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [KW-1:0] bit_idx;
   logic          sample_end, trial_end, last_bit;
   logic [N-1:0]  bit_mask, decided;

   assign sample_end = (cnt == CW'(SAMPLE_CYCLES - 1));
   assign trial_end  = (cnt == CW'(SETTLE_CYCLES));
   assign last_bit   = (bit_idx == '0);
   assign bit_mask   = {{(N-1){1'b0}}, 1'b1} << bit_idx;
   // Trial bit survives only if the analog input is at or above the trial code.
   assign decided    = cmp ? dac_code : (dac_code & ~bit_mask);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start) state_nxt = S_SAMPLE;
         S_SAMPLE:  if (sample_end) state_nxt = S_CONVERT;
         S_CONVERT: if (trial_end && last_bit) state_nxt = S_DONE;
         S_DONE:    if (ready) state_nxt = start ? S_SAMPLE : S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      sample = (state == S_SAMPLE);
      busy   = (state != S_IDLE);
      valid  = (state == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         bit_idx  <= '0;
         dac_code <= '0;
         result   <= '0;
      end else begin
         case (state)
            S_IDLE: cnt <= '0;
            S_SAMPLE: begin
               if (sample_end) begin
                  cnt      <= '0;
                  bit_idx  <= KW'(N - 1);
                  dac_code <= {1'b1, {(N-1){1'b0}}};
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_CONVERT: begin
               if (trial_end) begin
                  cnt <= '0;
                  if (last_bit) begin
                     result   <= decided;
                     dac_code <= decided;
                  end else begin
                     dac_code <= decided | (bit_mask >> 1);
                     bit_idx  <= bit_idx - KW'(1);
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_DONE: begin
               cnt <= '0;
               if (ready) dac_code <= '0;
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - directed bench for sar_adc_ctrl, default and N=4 instances
// Comparator is modelled as cmp = (vin >= dac_code).
module tb_sar_adc_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, ready, cmp;
   logic       sample, busy, valid;
   logic [7:0] dac_code, result, vin;

   logic       start4, ready4, cmp4;
   logic       sample4, busy4, valid4;
   logic [3:0] dac4, result4, vin4;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign cmp  = (vin >= dac_code);
   assign cmp4 = (vin4 >= dac4);

   sar_adc_ctrl u_dut (
      .clk(clk), .rst(rst), .start(start), .cmp(cmp), .sample(sample),
      .dac_code(dac_code), .busy(busy), .result(result), .valid(valid), .ready(ready)
   );

   sar_adc_ctrl #(.N(4), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(0)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .cmp(cmp4), .sample(sample4),
      .dac_code(dac4), .busy(busy4), .result(result4), .valid(valid4), .ready(ready4)
   );

   typedef struct {
      logic [7:0]  vin;
      logic [7:0]  exp;
      logic [63:0] trials;
   } vec_t;

   vec_t vecs[5];
   vec_t v11;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_conv(input vec_t v);
      int e;
      int idx;
      vin   = v.vin;
      ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk($sformatf("sample_e0_%h", v.vin), 32'(sample), 1);
      chk($sformatf("busy_e0_%h", v.vin), 32'(busy), 1);
      chk($sformatf("dac_e0_%h", v.vin), 32'(dac_code), 0);
      e = 0;
      while (!valid && e < 100) begin
         tick();
         e++;
         if (!valid && e >= 2 && e < 18) begin
            idx = (e - 2) / 2;
            chk($sformatf("trial_%h_e%0d", v.vin, e), 32'(dac_code), 32'(v.trials[63-8*idx -: 8]));
         end
      end
      chk($sformatf("valid_edge_%h", v.vin), e, 18);
      chk($sformatf("result_%h", v.vin), 32'(result), 32'(v.exp));
      chk($sformatf("dac_done_%h", v.vin), 32'(dac_code), 32'(v.exp));
      tick();
      chk($sformatf("valid_drop_%h", v.vin), 32'(valid), 0);
      chk($sformatf("busy_drop_%h", v.vin), 32'(busy), 0);
      chk($sformatf("dac_idle_%h", v.vin), 32'(dac_code), 0);
   endtask

   task automatic wait_valid(input string name);
      int e;
      e = 0;
      while (!valid && e < 100) begin
         tick();
         e++;
      end
      chk(name, 32'(valid), 1);
   endtask

   initial begin
      int  e;
      bit  dropped;
      logic [3:0] exp4 [4];

      vecs[0] = '{8'hA5, 8'hA5, 64'h80C0A0B0A8A4A6A5};
      vecs[1] = '{8'h00, 8'h00, 64'h8040201008040201};
      vecs[2] = '{8'hFF, 8'hFF, 64'h80C0E0F0F8FCFEFF};
      vecs[3] = '{8'h3C, 8'h3C, 64'h804020303C3C3E3D ^ 64'h0000000004000000};
      vecs[4] = '{8'h5A, 8'h5A, 64'h804060505C5C5A5B ^ 64'h0000000004000000};
      v11     = '{8'h11, 8'h11, 64'h8040201018141211};
      exp4    = '{4'h8, 4'hC, 4'hA, 4'h9};

      rst = 1'b1; start = 1'b0; ready = 1'b0; vin = 8'h00;
      start4 = 1'b0; ready4 = 1'b1; vin4 = 4'h0;
      #1;
      chk("rst_sample", 32'(sample), 0);
      chk("rst_dac", 32'(dac_code), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_valid4", 32'(valid4), 0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) run_conv(vecs[i]);

      // Backpressure: valid/result/dac stay put and start is ignored while ready is low.
      vin = 8'h3C; ready = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid("bp_valid_rise");
      for (int i = 0; i < 5; i++) begin
         start = (i % 2 == 0);
         tick();
         chk($sformatf("bp_valid_%0d", i), 32'(valid), 1);
         chk($sformatf("bp_result_%0d", i), 32'(result), 32'h3C);
         chk($sformatf("bp_dac_%0d", i), 32'(dac_code), 32'h3C);
         chk($sformatf("bp_sample_%0d", i), 32'(sample), 0);
      end
      start = 1'b0; ready = 1'b1;
      tick();
      chk("bp_valid_drop", 32'(valid), 0);
      chk("bp_busy_drop", 32'(busy), 0);

      // Back-to-back: start held at the handshake edge.
      vin = 8'hA5; ready = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid("b2b_first_valid");
      chk("b2b_first_result", 32'(result), 32'hA5);
      start = 1'b1; vin = 8'h5A; ready = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b_valid_drop", 32'(valid), 0);
      chk("b2b_sample", 32'(sample), 1);
      chk("b2b_busy", 32'(busy), 1);
      e = 0; dropped = 1'b0;
      while (!valid && e < 100) begin
         tick();
         e++;
         if (!busy) dropped = 1'b1;
      end
      chk("b2b_valid_edge", e, 18);
      chk("b2b_busy_held", 32'(dropped), 0);
      chk("b2b_result", 32'(result), 32'h5A);
      tick();
      chk("b2b_idle", 32'(busy), 0);

      // Reset asserted asynchronously during the bit-4 trial.
      vin = 8'hFF; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("mid_trial4_dac", 32'(dac_code), 32'hF0);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_sample", 32'(sample), 0);
      chk("mid_rst_dac", 32'(dac_code), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_result", 32'(result), 0);
      chk("mid_rst_valid", 32'(valid), 0);
      tick();
      rst = 1'b0;
      tick();
      chk("mid_rst_idle", 32'(busy), 0);
      run_conv(v11);

      // N=4, SAMPLE_CYCLES=1, SETTLE_CYCLES=0 instance.
      vin4 = 4'h9; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      chk("n4_sample_e0", 32'(sample4), 1);
      e = 0;
      while (!valid4 && e < 50) begin
         tick();
         e++;
         if (!valid4 && e >= 1 && e <= 4)
            chk($sformatf("n4_trial_e%0d", e), 32'(dac4), 32'(exp4[e-1]));
      end
      chk("n4_valid_edge", e, 5);
      chk("n4_result", 32'(result4), 32'h9);
      tick();
      chk("n4_valid_drop", 32'(valid4), 0);
      chk("n4_busy_drop", 32'(busy4), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/sar_adc_ctrl.md
# sar_adc_ctrl

Successive-approximation controller that drives the N-bit code input of the ideal DAC and reads back a single-bit comparator to digitise an analog input. It sits directly upstream of the DAC: its `dac_code` bus is wired bit-for-bit to the DAC input. Bit i of `dac_code` carries weight 2^i, so bit 0 is the LSB. The converted word is handed downstream on a valid/ready interface.

## Interface
- `N`, default 8 — resolution; width of `dac_code` and `result`. Must match the DAC's `dac_size`. Legal range ≥ 2.
- `SAMPLE_CYCLES`, default 2 — number of cycles `sample` is held high before bit trials start. Legal range ≥ 1.
- `SETTLE_CYCLES`, default 1 — extra wait cycles per bit trial, allowing for DAC rise/fall settling. Legal range ≥ 0.

- `clk` input 1 — single clock; all logic is clocked on the rising edge.
- `rst` input 1 — reset; asynchronous, active-high.
- `start` input 1 — requests a conversion.
- `cmp` input 1 — comparator output; 1 when the analog input is ≥ the DAC output.
- `sample` output 1 — track/hold control; 1 = track.
- `dac_code` output N — trial code driven to the DAC.
- `busy` output 1 — 1 whenever the state is not IDLE.
- `result` output N — converted code.
- `valid` output 1 — `result` is available.
- `ready` input 1 — downstream accepts `result`.

## Operation
- Reset values: state=IDLE; `sample`=0, `dac_code`=0, `busy`=0, `result`=0, `valid`=0.
- **IDLE**
  - `start`=1 at an edge → SAMPLE.
  - `start` is ignored in every other state except DONE (see back-to-back rule).
- **SAMPLE**
  - Outputs: `sample`=1, `dac_code`=0.
  - Lasts exactly SAMPLE_CYCLES cycles, then → CONVERT.
- **CONVERT**
  - Bit index k runs from N-1 down to 0. Each trial lasts SETTLE_CYCLES+1 cycles.
  - On entering trial k, `dac_code` = (bits already decided) | (1<<k). All lower bits are 0.
  - `cmp` is sampled only at the last edge of a trial:
    - cmp=1 → keep bit k.
    - cmp=0 → clear bit k.
  - `cmp` is don't-care on all other edges.
- **Finishing a conversion**
  - At the decision edge for k=0:
    - `result` ← final code.
    - `dac_code` ← final code, and holds that value through DONE.
    - `valid` ← 1.
    - state → DONE.
- **DONE**
  - `valid`=1; `result` is held stable.
  - `valid`&&`ready` at an edge completes the handshake: `valid` → 0.
    - If `start` is also 1 at that edge → SAMPLE (back-to-back conversion).
    - Otherwise → IDLE, and `dac_code` → 0.
  - `ready` is ignored when `valid`=0.
- **Width rules**
  - The counters must fit max(SAMPLE_CYCLES, SETTLE_CYCLES+1) and N.
  - Code arithmetic is pure bitwise set/clear; carries are impossible.
- **Reset mid-operation:** all outputs return to their reset values immediately, and any partial code is discarded.

## Timing
- Take E0 as the edge at which `start` is sampled in IDLE.
- SAMPLE occupies the cycles after E0 through E_S, where S = SAMPLE_CYCLES:
  - `sample` is 1 from E0 to E_S.
  - `busy` is 1 from E0 onward.
- Trial for bit k:
  - Begins at edge E_S + (N-1-k)(SETTLE_CYCLES+1).
  - Its decision edge is at E_S + (N-k)(SETTLE_CYCLES+1).
- `valid` rises at E_{S+N(SETTLE_CYCLES+1)}. With the default parameters this is E18.
- Handshake edge Eh:
  - `valid`=0 and `busy`=0 after Eh (when `start`=0).
  - Minimum period between `valid` pulses in back-to-back mode: S+N(SETTLE_CYCLES+1)+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
Comparator model for all scenarios: cmp = (VIN ≥ dac_code), where VIN is an integer code held by the bench. Default parameters.

- **Nominal conversion:** VIN=0xA5, pulse `start`, `ready`=1.
  - Trial codes: 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5, each held for 2 cycles.
  - `result`=0xA5 with `valid` at E18, then `busy`=0 at E19.
- **Extremes:**
  - VIN=0x00 → `result`=0x00 (every trial rejected).
  - VIN=0xFF → `result`=0xFF (every trial kept).
  - `valid` timing is identical to the nominal case.
- **Backpressure:** VIN=0x3C, `ready`=0 for 5 cycles after `valid`.
  - `valid`, `result`=0x3C and `dac_code` stay stable.
  - `start` pulses during this time are ignored.
  - Raise `ready` → `valid` drops on the next edge.
- **Back-to-back:** at the handshake edge, hold `start`=1 and change VIN to 0x5A.
  - `sample` goes high the next cycle and `busy` never drops.
  - Second `result`=0x5A with `valid` at Eh+18.
- **Reset mid-conversion:** assert `rst` during the trial for bit 4.
  - All outputs go to 0 immediately.
  - After release, a new `start` with VIN=0x11 gives `result`=0x11.
- **Parameter sweep:** N=4, SAMPLE_CYCLES=1, SETTLE_CYCLES=0, VIN=0x9.
  - Trial codes: 0x8, 0xC, 0xA, 0x9.
  - `valid` at E5.
